// File: rtl/jellyvl_muladd_unsigned_multicycle.sv
// Unsigned multicycle multiply-add (m_product = s_a * s_b + s_c), one multiplier bit per cycle.
// Shift-add datapath with valid/ready on both sides; no overlap between operations.
module jellyvl_muladd_unsigned_multicycle #(
  parameter int unsigned A_WIDTH = 32,
  parameter int unsigned B_WIDTH = 32,
  parameter int unsigned C_WIDTH = B_WIDTH,
  parameter int unsigned P_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cke,
  input  logic [A_WIDTH-1:0] s_a,
  input  logic [B_WIDTH-1:0] s_b,
  input  logic [C_WIDTH-1:0] s_c,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [P_WIDTH-1:0] m_product,
  output logic               m_overflow,
  output logic               m_valid,
  input  logic               m_ready
);

  localparam int unsigned AB_W  = A_WIDTH + B_WIDTH;
  // One spare bit above the widest term so the accumulator never wraps.
  localparam int unsigned ACC_W = ((AB_W > C_WIDTH) ? AB_W : C_WIDTH) + 1;
  localparam int unsigned CNT_W = (A_WIDTH > 1) ? $clog2(A_WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   b_reg;
  logic [ACC_W-1:0]   acc_step;
  logic [A_WIDTH-1:0] a_reg;
  logic [CNT_W-1:0]   cnt;
  logic [P_WIDTH-1:0] prod_w;
  logic               ovf_w;

  assign acc_step = a_reg[0] ? (acc + b_reg) : acc;
  assign s_ready  = cke && (state == StIdle);

  generate
    if (P_WIDTH < ACC_W) begin : g_trunc
      assign prod_w = acc_step[P_WIDTH-1:0];
      assign ovf_w  = |acc_step[ACC_W-1:P_WIDTH];
    end else begin : g_ext
      assign prod_w = P_WIDTH'(acc_step);
      assign ovf_w  = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= StIdle;
      m_valid    <= 1'b0;
      m_product  <= '0;
      m_overflow <= 1'b0;
      acc        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      cnt        <= '0;
    end else if (cke) begin
      unique case (state)
        StIdle: begin
          if (s_valid) begin
            acc   <= ACC_W'(s_c);
            a_reg <= s_a;
            b_reg <= ACC_W'(s_b);
            cnt   <= CNT_W'(A_WIDTH - 1);
            state <= StRun;
          end
        end
        StRun: begin
          acc   <= acc_step;
          a_reg <= a_reg >> 1;
          b_reg <= b_reg << 1;
          cnt   <= cnt - CNT_W'(1);
          // Last step: capture the post-step accumulator directly into the outputs.
          if (cnt == '0) begin
            m_product  <= prod_w;
            m_overflow <= ovf_w;
            m_valid    <= 1'b1;
            state      <= StDone;
          end
        end
        StDone: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jellyvl_muladd_unsigned_multicycle.sv
// Scoreboard bench for the multicycle multiply-add: a 32x32 instance and an 8-bit instance.
module tb_jellyvl_muladd_unsigned_multicycle;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cke = 1'b1;

  logic [31:0] s_a, s_b, s_c;
  logic        s_valid, s_ready;
  logic [63:0] m_product;
  logic        m_overflow, m_valid, m_ready;

  logic [7:0]  s_a8, s_b8, s_c8;
  logic        s_valid8, s_ready8;
  logic [7:0]  m_product8;
  logic        m_overflow8, m_valid8, m_ready8;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [63:0] qp[$];
  bit          qo[$];
  logic [63:0] qp8[$];
  bit          qo8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jellyvl_muladd_unsigned_multicycle u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cke        (cke),
    .s_a        (s_a),
    .s_b        (s_b),
    .s_c        (s_c),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_product  (m_product),
    .m_overflow (m_overflow),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  jellyvl_muladd_unsigned_multicycle #(
    .A_WIDTH (8),
    .B_WIDTH (8),
    .C_WIDTH (8),
    .P_WIDTH (8)
  ) u_dut8 (
    .clk        (clk),
    .reset_n    (reset_n),
    .cke        (cke),
    .s_a        (s_a8),
    .s_b        (s_b8),
    .s_c        (s_c8),
    .s_valid    (s_valid8),
    .s_ready    (s_ready8),
    .m_product  (m_product8),
    .m_overflow (m_overflow8),
    .m_valid    (m_valid8),
    .m_ready    (m_ready8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the scoreboard on each output handshake.
  always @(negedge clk) begin
    if (m_valid && m_ready && cke) begin
      if (qp.size() == 0) begin
        check("unexpected_result32", 64'd1, 64'd0);
      end else begin
        check("product32", m_product, qp.pop_front());
        check("overflow32", 64'(m_overflow), 64'(qo.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid8 && m_ready8 && cke) begin
      if (qp8.size() == 0) begin
        check("unexpected_result8", 64'd1, 64'd0);
      end else begin
        check("product8", 64'(m_product8), qp8.pop_front());
        check("overflow8", 64'(m_overflow8), 64'(qo8.pop_front()));
      end
    end
  end

  // Present operands until accepted; returns the cycle stamp just after the accepting edge.
  task automatic issue(input bit w8, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [63:0] exp_p, input bit exp_o,
                       output int acc_cyc);
    int n = 0;
    if (w8) begin
      s_a8 = a[7:0]; s_b8 = b[7:0]; s_c8 = c[7:0]; s_valid8 = 1'b1;
    end else begin
      s_a = a; s_b = b; s_c = c; s_valid = 1'b1;
    end
    acc_cyc = 0;
    forever begin
      @(negedge clk);
      if (w8 ? s_ready8 : s_ready) break;
      n++;
      if (n > 1000) begin
        check("accept_timeout", 64'd0, 64'd1);
        s_valid = 1'b0; s_valid8 = 1'b0;
        return;
      end
    end
    if (w8) begin
      qp8.push_back(exp_p); qo8.push_back(exp_o);
    end else begin
      qp.push_back(exp_p); qo.push_back(exp_o);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    s_valid = 1'b0; s_valid8 = 1'b0;
  endtask

  task automatic wait_valid(input bit w8, input int acc_cyc, output int lat);
    int n = 0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (w8 ? m_valid8 : m_valid) break;
      n++;
      if (n > 1000) begin
        check("valid_timeout", 64'd0, 64'd1);
        return;
      end
    end
    lat = cyc - acc_cyc;
  endtask

  task automatic run(input bit w8, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input logic [63:0] exp_p, input bit exp_o);
    int ac, lat;
    issue(w8, a, b, c, exp_p, exp_o, ac);
    wait_valid(w8, ac, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    int ac, lat, idle;
    logic [31:0] q, d, r;
    s_a = '0; s_b = '0; s_c = '0; s_valid = 1'b0; m_ready = 1'b1;
    s_a8 = '0; s_b8 = '0; s_c8 = '0; s_valid8 = 1'b0; m_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_m_valid", 64'(m_valid), 64'd0);
    check("reset_m_product", m_product, 64'd0);
    check("reset_m_overflow", 64'(m_overflow), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;

    // Basic op, latency and single-cycle valid pulse
    issue(0, 32'd7, 32'd9, 32'd5, 64'd68, 1'b0, ac);
    wait_valid(0, ac, lat);
    check("latency_basic", 64'(lat), 64'd32);
    @(posedge clk); #1;
    @(negedge clk);
    check("valid_one_cycle", 64'(m_valid), 64'd0);
    @(posedge clk); #1;

    // Extremes
    run(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 1'b0);
    run(0, 32'd0, 32'h1234, 32'hABCD, 64'hABCD, 1'b0);
    run(0, 32'h1234, 32'd0, 32'd77, 64'd77, 1'b0);

    // Divider round trip: quotient * divisor + remainder == dividend
    for (int i = 0; i < 200; i++) begin
      q = $urandom;
      d = $urandom;
      if (d == 0) d = 32'd1;
      r = $urandom % d;
      run(0, q, d, r, 64'(q) * 64'(d) + 64'(r), 1'b0);
    end

    // Backpressure: outputs hold, new operands ignored
    m_ready = 1'b0;
    issue(0, 32'd3, 32'd5, 32'd1, 64'd16, 1'b0, ac);
    wait_valid(0, ac, lat);
    s_a = 32'd99; s_b = 32'd99; s_c = 32'd99; s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_m_valid", 64'(m_valid), 64'd1);
      check("stall_m_product", m_product, 64'd16);
      check("stall_s_ready", 64'(s_ready), 64'd0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_handshake_s_ready", 64'(s_ready), 64'd1);
    check("post_handshake_m_valid", 64'(m_valid), 64'd0);
    @(posedge clk); #1;

    // Random clock-enable gaps stretch the latency by the idle count
    idle = 0;
    issue(0, 32'd100, 32'd200, 32'd7, 64'd20007, 1'b0, ac);
    for (int i = 0; i < 20; i++) begin
      cke = 1'($urandom);
      if (!cke) idle++;
      @(posedge clk); #1;
    end
    cke = 1'b1;
    wait_valid(0, ac, lat);
    check("latency_cke", 64'(lat), 64'(32 + idle));
    @(posedge clk); #1;

    // Narrow instance: truncation and overflow flag
    run(1, 32'd16, 32'd16, 32'd0, 64'h00, 1'b1);
    run(1, 32'd15, 32'd17, 32'd0, 64'hFF, 1'b0);
    run(1, 32'd255, 32'd255, 32'd255, 64'h00, 1'b1);
    run(1, 32'd0, 32'd0, 32'd200, 64'd200, 1'b0);

    // Reset mid-run discards the pending op
    issue(0, 32'd1234, 32'd5678, 32'd9, 64'd0, 1'b0, ac);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("reset_midrun_m_valid", 64'(m_valid), 64'd0);
    qp.delete();
    qo.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("after_reset_s_ready", 64'(s_ready), 64'd1);
    check("after_reset_m_valid", 64'(m_valid), 64'd0);
    @(posedge clk); #1;
    run(0, 32'd6, 32'd7, 32'd8, 64'd50, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(qp.size() + qp8.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
